// File: rtl/pc_unit.sv
// Program-counter stage: loads the PC from a two-word reset vector, then sequences,
// redirects on taken jumps, and freezes on stall or halt.
module pc_unit #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
    parameter int          PC_W           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            taken,
    input  logic [PC_W-1:0] target,
    input  logic            stall,
    input  logic            is_32bit,
    input  logic            halt,
    input  logic [15:0]     imem_data,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            flush
);

    typedef enum logic [1:0] {
        LD_HI  = 2'd0,
        LD_LO  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_reg + (is_32bit ? PC_W'(2) : PC_W'(1));

    // A taken jump outranks halt and stall: the jump is older than the instruction
    // that is stalling or halting, so that instruction was on a wrong path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= LD_HI;
            pc_reg    <= '0;
        end else begin
            case (state_reg)
                LD_HI: begin
                    pc_reg[PC_W-1:16] <= imem_data;
                    state_reg         <= LD_LO;
                end
                LD_LO: begin
                    pc_reg[15:0] <= imem_data;
                    state_reg    <= RUN;
                end
                RUN: begin
                    if (taken) begin
                        pc_reg <= target;
                    end else if (halt) begin
                        state_reg <= HALTED;
                    end else if (!stall) begin
                        pc_reg <= pc_inc;
                    end
                end
                HALTED: begin
                    if (taken) begin
                        pc_reg    <= target;
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= LD_HI;
            endcase
        end
    end

    always_comb begin
        imem_addr = pc_reg;
        case (state_reg)
            LD_HI:   imem_addr = RESET_VEC_ADDR;
            LD_LO:   imem_addr = RESET_VEC_ADDR + 32'd1;
            default: imem_addr = pc_reg;
        endcase
    end

    assign pc          = pc_reg;
    assign flush       = taken && ((state_reg == RUN) || (state_reg == HALTED));
    assign fetch_valid = (state_reg == RUN) && !stall && !taken && !halt;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for RUN/HALTED sequencing plus
// hand-written sequences for reset-vector loading and asynchronous reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        taken = 1'b0;
    logic [31:0] target = 32'd0;
    logic        stall = 1'b0;
    logic        is_32bit = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;

    logic [15:0] vhi = 16'h0000;
    logic [15:0] vlo = 16'h0100;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: only the two reset-vector words are meaningful.
    assign imem_data = (imem_addr == 32'd0) ? vhi :
                       (imem_addr == 32'd1) ? vlo : 16'hDEAD;

    pc_unit #(.RESET_VEC_ADDR(32'd0), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .taken      (taken),
        .target     (target),
        .stall      (stall),
        .is_32bit   (is_32bit),
        .halt       (halt),
        .imem_data  (imem_data),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .flush      (flush)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        stall;
        logic        is_32bit;
        logic        halt;
        logic [31:0] exp_addr;
        logic        exp_fv;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           taken target        stall is32 halt addr          fv    flush pc_next
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000100, 1'b1, 1'b0, 32'h00000101};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000101, 1'b1, 1'b0, 32'h00000103};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000103, 1'b1, 1'b0, 32'h00000104};
        vecs[3]  = '{1'b1, 32'h200,      1'b0, 1'b0, 1'b0, 32'h00000104, 1'b0, 1'b1, 32'h00000200};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00000200, 1'b0, 1'b0, 32'h00000200};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h00000200, 1'b0, 1'b0, 32'h00000200};
        vecs[6]  = '{1'b1, 32'hABCD,     1'b1, 1'b0, 1'b0, 32'h00000200, 1'b0, 1'b1, 32'h0000ABCD};
        vecs[7]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h0000ABCD, 1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
        vecs[13] = '{1'b1, 32'h3,        1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00000003};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000003, 1'b1, 1'b0, 32'h00000004};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00000004, 1'b0, 1'b0, 32'h00000004};
        vecs[16] = '{1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000004, 1'b0, 1'b1, 32'h00000000};
        vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000002};

        // Reset held low, with a jump request that must be ignored
        taken  = 1'b1;
        target = 32'h5555;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Release reset: LD_HI, LD_LO, then the first RUN fetch
        tick();
        rst = 1'b1;
        #1;
        chk("ldhi_addr", imem_addr, 32'h0);
        chk("ldhi_fv", 32'(fetch_valid), 32'h0);
        chk("ldhi_flush", 32'(flush), 32'h0);
        tick();
        chk("ldlo_addr", imem_addr, 32'h1);
        chk("ldlo_pc", pc, 32'h0);
        chk("ldlo_fv", 32'(fetch_valid), 32'h0);
        chk("ldlo_flush", 32'(flush), 32'h0);
        tick();
        taken = 1'b0;
        #1;
        chk("vec_pc", pc, 32'h100);
        chk("vec_fv", 32'(fetch_valid), 32'h1);
        chk("vec_addr", imem_addr, 32'h100);
        $display("reset vector load: pc=%h", pc);

        for (int i = 0; i < 18; i++) begin
            taken    = vecs[i].taken;
            target   = vecs[i].target;
            stall    = vecs[i].stall;
            is_32bit = vecs[i].is_32bit;
            halt     = vecs[i].halt;
            #1;
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_fv", i), 32'(fetch_valid), 32'(vecs[i].exp_fv));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
            tick();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            $display("vec %0d: taken=%b tgt=%h stall=%b w32=%b halt=%b -> pc=%h",
                     i, vecs[i].taken, vecs[i].target, vecs[i].stall,
                     vecs[i].is_32bit, vecs[i].halt, pc);
        end

        // Halt at 0x300 and stay frozen for 10 cycles, then wrong-path recovery
        taken = 1'b1; target = 32'h300; stall = 1'b0; is_32bit = 1'b0; halt = 1'b0;
        tick();
        taken = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall    = i[0];
            is_32bit = ~i[0];
            #1;
            chk($sformatf("hlt%0d_fv", i), 32'(fetch_valid), 32'h0);
            tick();
            chk($sformatf("hlt%0d_pc", i), pc, 32'h300);
        end
        stall = 1'b0; is_32bit = 1'b0;
        taken = 1'b1; target = 32'h400;
        #1;
        chk("hlt_exit_flush", 32'(flush), 32'h1);
        tick();
        taken = 1'b0;
        chk("hlt_exit_pc", pc, 32'h400);
        #1;
        chk("hlt_exit_fv", 32'(fetch_valid), 32'h1);
        $display("halt sequence: resumed at pc=%h", pc);

        // Asynchronous reset mid-RUN: pc clears before the next edge
        vhi = 16'h1234;
        vlo = 16'h5678;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_fv", 32'(fetch_valid), 32'h0);
        tick();
        chk("arst_hold_pc", pc, 32'h0);
        rst = 1'b1;
        taken = 1'b1; target = 32'hBAD0;
        #1;
        chk("arst_ldhi_flush", 32'(flush), 32'h0);
        tick();
        chk("arst_ldlo_pc", pc, 32'h12340000);
        chk("arst_ldlo_addr", imem_addr, 32'h1);

        // Reset again while in LD_LO: load restarts from LD_HI
        #2;
        rst = 1'b0;
        #1;
        chk("ldlo_rst_pc", pc, 32'h0);
        chk("ldlo_rst_addr", imem_addr, 32'h0);
        rst = 1'b1;
        #1;
        chk("reload_hi_addr", imem_addr, 32'h0);
        tick();
        chk("reload_lo_pc", pc, 32'h12340000);
        chk("reload_lo_flush", 32'(flush), 32'h0);
        tick();
        taken = 1'b0;
        #1;
        chk("reload_pc", pc, 32'h12345678);
        chk("reload_fv", 32'(fetch_valid), 32'h1);
        $display("reload after reset: pc=%h", pc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
